// File: rtl/output_write_pkg.sv
// Shared constants for the output write sequencer: mode encodings and default sizing.
package output_write_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_AUTO = 1'b1;

  localparam int DEF_NUM_SLOTS = 16;
  localparam int DEF_DATA_W    = 64;

endpackage

// File: rtl/output_write_sequencer_if.sv
// Result-word handshake, slot bank strobes and occupancy signals between the search core side and the sequencer.
interface output_write_sequencer_if
  import output_write_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int DATA_W    = DEF_DATA_W
);
  localparam int SEL_W = $clog2(NUM_SLOTS);

  logic                 mode_i;
  logic [SEL_W-1:0]     select_i;
  logic [DATA_W-1:0]    data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [NUM_SLOTS-1:0] write_o;
  logic [DATA_W-1:0]    data_o;
  logic [NUM_SLOTS-1:0] release_i;
  logic [NUM_SLOTS-1:0] full_o;
  logic                 all_full_o;
  logic [SEL_W-1:0]     ptr_o;
  logic                 err_o;

  modport master (
    output mode_i, select_i, data_i, valid_i, release_i,
    input  ready_o, write_o, data_o, full_o, all_full_o, ptr_o, err_o
  );

  modport slave (
    input  mode_i, select_i, data_i, valid_i, release_i,
    output ready_o, write_o, data_o, full_o, all_full_o, ptr_o, err_o
  );

endinterface

// File: rtl/output_write_sequencer_slot_pointer.sv
// Modulo-NUM_SLOTS wrap counter used as the auto-mode target pointer.
module slot_pointer #(
  parameter int NUM_SLOTS = 16,
  parameter int SEL_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  output logic [SEL_W-1:0] ptr
);

  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;

  // Explicit wrap so non-power-of-two slot counts never reach an unused index.
  always_comb begin
    ptr_next = ptr_reg;
    if (inc) begin
      if (ptr_reg == SEL_W'(NUM_SLOTS - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = ptr_reg + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/output_write_sequencer.sv
// Steers accepted result words into output slots (addressed or round-robin) and tracks
// per-slot occupancy so unread results are never overwritten.
module output_write_sequencer
  import output_write_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output_write_sequencer_if.slave   bus
);

  localparam int SEL_W = $clog2(NUM_SLOTS);

  logic [SEL_W-1:0]     ptr;
  logic [SEL_W-1:0]     target;
  logic [NUM_SLOTS-1:0] target_onehot;
  logic                 in_range;
  logic                 target_full;
  logic                 accept;
  logic                 wr_en;
  logic                 err_next;
  logic                 ptr_inc;

  logic [NUM_SLOTS-1:0] full_reg;
  logic [NUM_SLOTS-1:0] full_next;
  logic [NUM_SLOTS-1:0] write_reg;
  logic [NUM_SLOTS-1:0] write_next;
  logic [DATA_W-1:0]    data_reg;
  logic                 err_reg;

  assign target = (bus.mode_i == MODE_AUTO) ? ptr : bus.select_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_decode
      assign target_onehot[gi] = (target == SEL_W'(gi));
    end

    // With a power-of-two slot count every select value is a real slot.
    if (NUM_SLOTS == (1 << SEL_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = ({1'b0, target} < (SEL_W + 1)'(NUM_SLOTS));
    end
  endgenerate

  // Out-of-range targets decode to an all-zero one-hot, so they always read as not full.
  assign target_full = |(full_reg & target_onehot);
  assign bus.ready_o = ~target_full;

  assign accept   = bus.valid_i & bus.ready_o;
  assign wr_en    = accept & in_range;
  assign err_next = accept & ~in_range;
  assign ptr_inc  = accept & (bus.mode_i == MODE_AUTO);

  always_comb begin
    write_next = '0;
    if (wr_en) begin
      write_next = target_onehot;
    end
    // Release clears the old content; a same-cycle write re-sets the flag.
    full_next = (full_reg & ~bus.release_i) | write_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_reg  <= '0;
      write_reg <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      full_reg  <= full_next;
      write_reg <= write_next;
      err_reg   <= err_next;
      if (wr_en) begin
        data_reg <= bus.data_i;
      end
    end
  end

  slot_pointer #(
    .NUM_SLOTS (NUM_SLOTS),
    .SEL_W     (SEL_W)
  ) u_slot_pointer (
    .clk  (clk_i),
    .srst (rst_i),
    .inc  (ptr_inc),
    .ptr  (ptr)
  );

  assign bus.write_o    = write_reg;
  assign bus.data_o     = data_reg;
  assign bus.full_o     = full_reg;
  assign bus.all_full_o = &full_reg;
  assign bus.ptr_o      = ptr;
  assign bus.err_o      = err_reg;

endmodule

// File: tb/tb_output_write_sequencer.sv
// Directed bench: a 16-slot and a 10-slot sequencer driven through auto, addressed,
// out-of-range, mode-switch and mid-stream reset scenarios.
module tb_output_write_sequencer;

  logic clk = 1'b0;
  logic rst16;
  logic rst10;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  output_write_sequencer_if #(.NUM_SLOTS(16), .DATA_W(64)) b16 ();
  output_write_sequencer_if #(.NUM_SLOTS(10), .DATA_W(64)) b10 ();

  output_write_sequencer #(.NUM_SLOTS(16), .DATA_W(64)) u16 (
    .clk_i (clk),
    .rst_i (rst16),
    .bus   (b16.slave)
  );

  output_write_sequencer #(.NUM_SLOTS(10), .DATA_W(64)) u10 (
    .clk_i (clk),
    .rst_i (rst10),
    .bus   (b10.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line per slot write transaction on either instance.
  always @(posedge clk) begin
    #1;
    if (|b16.write_o) $display("u16 write strobe=0x%04h data=0x%0h", b16.write_o, b16.data_o);
    if (|b10.write_o) $display("u10 write strobe=0x%03h data=0x%0h", b10.write_o, b10.data_o);
    if (b10.err_o)    $display("u10 out-of-range word discarded");
  end

  initial begin
    b16.mode_i = 1'b0; b16.select_i = '0; b16.data_i = '0; b16.valid_i = 1'b0; b16.release_i = '0;
    b10.mode_i = 1'b0; b10.select_i = '0; b10.data_i = '0; b10.valid_i = 1'b0; b10.release_i = '0;
    rst16 = 1'b1;
    rst10 = 1'b1;
    tick();
    tick();
    rst16 = 1'b0;
    rst10 = 1'b0;

    // Reset state
    chk("rst_write", 64'(b16.write_o), 64'h0);
    chk("rst_data", b16.data_o, 64'h0);
    chk("rst_full", 64'(b16.full_o), 64'h0);
    chk("rst_ptr", 64'(b16.ptr_o), 64'h0);
    chk("rst_err", 64'(b16.err_o), 64'h0);
    chk("rst_all_full", 64'(b16.all_full_o), 64'h0);
    chk("rst_ready", 64'(b16.ready_o), 64'h1);
    chk("rst_ready10", 64'(b10.ready_o), 64'h1);

    // Auto mode: fill all 16 slots back to back
    b16.mode_i  = 1'b1;
    b16.valid_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b16.data_i = 64'h100 + 64'(k);
      tick();
      chk("auto_write", 64'(b16.write_o), 64'd1 << k);
      chk("auto_data", b16.data_o, 64'h100 + 64'(k));
    end
    chk("auto_all_full", 64'(b16.all_full_o), 64'h1);
    chk("auto_ptr_wrap", 64'(b16.ptr_o), 64'h0);
    b16.data_i = 64'h110;
    #1;
    chk("auto_stall_ready", 64'(b16.ready_o), 64'h0);
    tick();
    chk("auto_stall_write", 64'(b16.write_o), 64'h0);
    chk("auto_stall_data", b16.data_o, 64'h10F);
    b16.release_i = 16'h0001;
    tick();
    b16.release_i = '0;
    chk("rel_full", 64'(b16.full_o), 64'hFFFE);
    chk("rel_ready", 64'(b16.ready_o), 64'h1);
    chk("rel_no_write", 64'(b16.write_o), 64'h0);
    tick();
    chk("held_write", 64'(b16.write_o), 64'h1);
    chk("held_data", b16.data_o, 64'h110);
    chk("held_full", 64'(b16.full_o), 64'hFFFF);
    chk("held_ptr", 64'(b16.ptr_o), 64'h1);
    b16.valid_i = 1'b0;

    // Addressed slot 5: stall, release, then release+write same cycle
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    b16.mode_i   = 1'b0;
    b16.select_i = 4'd5;
    b16.valid_i  = 1'b1;
    b16.data_i   = 64'h5A;
    tick();
    chk("addr_write", 64'(b16.write_o), 64'h20);
    chk("addr_full", 64'(b16.full_o), 64'h20);
    b16.data_i = 64'h5B;
    #1;
    chk("addr_stall_ready", 64'(b16.ready_o), 64'h0);
    tick();
    chk("addr_stall_write", 64'(b16.write_o), 64'h0);
    chk("addr_stall_data", b16.data_o, 64'h5A);
    b16.release_i = 16'h0020;
    tick();
    chk("addr_rel_full", 64'(b16.full_o), 64'h0);
    chk("addr_rel_ready", 64'(b16.ready_o), 64'h1);
    tick();
    chk("setwins_write", 64'(b16.write_o), 64'h20);
    chk("setwins_data", b16.data_o, 64'h5B);
    chk("setwins_full", 64'(b16.full_o), 64'h20);
    chk("setwins_ptr", 64'(b16.ptr_o), 64'h0);
    b16.release_i = '0;
    b16.valid_i   = 1'b0;
    tick();
    chk("idle_write", 64'(b16.write_o), 64'h0);
    chk("idle_full", 64'(b16.full_o), 64'h20);

    // 10 slots: out-of-range addressed write, then auto wrap 9 -> 0
    b10.mode_i   = 1'b0;
    b10.select_i = 4'd3;
    b10.valid_i  = 1'b1;
    b10.data_i   = 64'h33;
    tick();
    chk("n10_write3", 64'(b10.write_o), 64'h8);
    chk("n10_full3", 64'(b10.full_o), 64'h8);
    b10.select_i = 4'd12;
    b10.data_i   = 64'hCC;
    #1;
    chk("oor_ready", 64'(b10.ready_o), 64'h1);
    tick();
    b10.valid_i = 1'b0;
    chk("oor_err", 64'(b10.err_o), 64'h1);
    chk("oor_write", 64'(b10.write_o), 64'h0);
    chk("oor_full", 64'(b10.full_o), 64'h8);
    chk("oor_data", b10.data_o, 64'h33);
    chk("oor_ptr", 64'(b10.ptr_o), 64'h0);
    tick();
    chk("oor_err_once", 64'(b10.err_o), 64'h0);
    b10.release_i = 10'h008;
    tick();
    b10.release_i = '0;
    chk("n10_rel", 64'(b10.full_o), 64'h0);
    b10.mode_i  = 1'b1;
    b10.valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b10.data_i = 64'h200 + 64'(k);
      tick();
      chk("n10_auto_write", 64'(b10.write_o), 64'd1 << k);
      chk("n10_auto_ptr", 64'(b10.ptr_o), 64'((k + 1) % 10));
    end
    b10.valid_i = 1'b0;
    chk("n10_all_full", 64'(b10.all_full_o), 64'h1);
    chk("n10_full", 64'(b10.full_o), 64'h3FF);

    // Mode switch keeps the auto pointer
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    b16.mode_i  = 1'b1;
    b16.valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b16.data_i = 64'h300 + 64'(k);
      tick();
    end
    chk("sw_ptr3", 64'(b16.ptr_o), 64'h3);
    b16.mode_i   = 1'b0;
    b16.select_i = 4'd7;
    b16.data_i   = 64'h377;
    tick();
    chk("sw_addr_write", 64'(b16.write_o), 64'h80);
    chk("sw_addr_ptr", 64'(b16.ptr_o), 64'h3);
    b16.mode_i = 1'b1;
    b16.data_i = 64'h3AA;
    tick();
    b16.valid_i = 1'b0;
    chk("sw_auto_write", 64'(b16.write_o), 64'h8);
    chk("sw_auto_data", b16.data_o, 64'h3AA);
    chk("sw_full", 64'(b16.full_o), 64'h008F);
    chk("sw_ptr4", 64'(b16.ptr_o), 64'h4);

    // Reset mid-stream with an accept in flight
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    b16.mode_i  = 1'b1;
    b16.valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b16.data_i = 64'h400 + 64'(k);
      tick();
    end
    chk("pre_rst_ptr", 64'(b16.ptr_o), 64'h6);
    chk("pre_rst_full", 64'(b16.full_o), 64'h3F);
    rst16 = 1'b1;
    b16.data_i = 64'h777;
    tick();
    chk("mid_rst_write", 64'(b16.write_o), 64'h0);
    chk("mid_rst_full", 64'(b16.full_o), 64'h0);
    chk("mid_rst_ptr", 64'(b16.ptr_o), 64'h0);
    chk("mid_rst_data", b16.data_o, 64'h0);
    chk("mid_rst_err", 64'(b16.err_o), 64'h0);
    chk("mid_rst_all_full", 64'(b16.all_full_o), 64'h0);
    rst16 = 1'b0;
    b16.valid_i = 1'b0;
    #1;
    chk("post_rst_ready", 64'(b16.ready_o), 64'h1);
    tick();
    chk("post_rst_write", 64'(b16.write_o), 64'h0);
    chk("post_rst_data", b16.data_o, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
